// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754-style multiplier: shift-add significand, normalise, RNE.
// Subnormal operands and results flush to zero; one operation in flight.
module fp_multiplier_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] input_a,
    input  logic [W-1:0] input_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int P  = MAN_W + 1;
    localparam int AW = 2 * P;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(P);

    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [P-1:0]           sig_a_q, sig_a_d;
    logic [P-1:0]           sig_b_q, sig_b_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MAN_W-1:0]       frac_q, frac_d;
    logic                   guard_q, guard_d;
    logic                   sticky_q, sticky_d;
    logic                   spec_q, spec_d;
    logic                   nan_q, nan_d;
    logic [W-1:0]           prod_q, prod_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   inv_q, inv_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             s_in;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             is_nan, is_spec;
    logic [W-1:0]     spec_res;

    assign ea   = input_a[W-2 -: EXP_W];
    assign eb   = input_b[W-2 -: EXP_W];
    assign fa   = input_a[MAN_W-1:0];
    assign fb   = input_b[MAN_W-1:0];
    assign s_in = input_a[W-1] ^ input_b[W-1];

    // Exponent 0 means zero: subnormal inputs are treated as zero.
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (fa == '0);
    assign b_inf   = (eb == '1) && (fb == '0);
    assign a_nan   = (ea == '1) && (fa != '0);
    assign b_nan   = (eb == '1) && (fb != '0);
    assign is_nan  = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
    assign is_spec = is_nan || a_inf || b_inf || a_zero || b_zero;

    always_comb begin
        spec_res = {s_in, {(W - 1){1'b0}}};
        if (is_nan) begin
            spec_res = QNAN;
        end else if (a_inf || b_inf) begin
            spec_res = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic [AW-1:0]        addend;
    logic                 msb;
    logic [MAN_W:0]       frac_sum;
    logic                 inc;
    logic signed [EW-1:0] exp_r;

    assign addend   = AW'(sig_a_q) << cnt_q;
    assign msb      = acc_q[AW-1];
    assign inc      = guard_q && (sticky_q || frac_q[0]);
    // Hidden bit is always 1 here, so a fraction carry means 10.000...
    assign frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
    assign exp_r    = exp_q + EW'(frac_sum[MAN_W]);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sig_a_d  = sig_a_q;
        sig_b_d  = sig_b_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        spec_d   = spec_q;
        nan_d    = nan_q;
        prod_d   = prod_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = s_in;
                    sig_a_d = {1'b1, fa};
                    sig_b_d = {1'b1, fb};
                    exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    acc_d   = '0;
                    cnt_d   = '0;
                    spec_d  = is_spec;
                    nan_d   = is_nan;
                    prod_d  = spec_res;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (spec_q) begin
                    inv_d   = nan_q;
                    state_d = DONE;
                end else begin
                    if (sig_b_q[cnt_q]) begin
                        acc_d = acc_q + addend;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(MAN_W)) begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (msb) begin
                    frac_d   = acc_q[AW-2 -: MAN_W];
                    guard_d  = acc_q[P-1];
                    sticky_d = |acc_q[P-2:0];
                    exp_d    = exp_q + EW'(1);
                end else begin
                    frac_d   = acc_q[AW-3 -: MAN_W];
                    guard_d  = acc_q[P-2];
                    sticky_d = |acc_q[P-3:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                if (exp_r >= EMAX) begin
                    prod_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d  = 1'b1;
                end else if (exp_r <= EZERO) begin
                    prod_d = {sign_q, {(W - 1){1'b0}}};
                    unf_d  = 1'b1;
                end else begin
                    prod_d = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            sig_a_q  <= '0;
            sig_b_q  <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            spec_q   <= 1'b0;
            nan_q    <= 1'b0;
            prod_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sig_a_q  <= sig_a_d;
            sig_b_q  <= sig_b_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            spec_q   <= spec_d;
            nan_q    <= nan_d;
            prod_q   <= prod_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Bench for fp_multiplier_seq (FP32): scoreboard of expected results,
// one task per scenario.
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    fp_multiplier_seq dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .input_a(input_a),
        .input_b(input_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .overflow(overflow),
        .underflow(underflow),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    localparam int LN = 26;
    localparam int LS = 1;

    // f = {overflow, underflow, invalid}
    typedef struct {
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready got=0 want=1");
        end
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        sb.push_back(e);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            cyc();
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_a   = '0;
        input_b   = '0;
        repeat (3) cyc();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if ({product, overflow, underflow, invalid} !== 35'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b%b%b want=0",
                     product, overflow, underflow, invalid);
        end
    endtask

    task automatic test_normal();
        logic [31:0] a[4] = '{32'h40400000, 32'hC0400000,
                              32'h3F800000, 32'h3FC00000};
        logic [31:0] b[4] = '{32'h40000000, 32'h40000000,
                              32'h3F800000, 32'h3FC00000};
        logic [31:0] p[4] = '{32'h40C00000, 32'hC0C00000,
                              32'h3F800000, 32'h40100000};
        exp_t e;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            send(a[i], b[i], '{p[i], 3'b000, LN});
            wait_out(lat);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || lat != e.lat) begin
                bad++;
                $display("FAIL normal_lat[%0d] got=%0d want=%0d",
                         i, lat, e.lat);
            end
            total++;
            if ({product, overflow, underflow, invalid} !== {e.p, e.f}) begin
                bad++;
                $display("FAIL normal_res[%0d] got=%h/%b%b%b want=%h/%b",
                         i, product, overflow, underflow, invalid, e.p, e.f);
            end
            take();
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL normal_idle got=%b%b want=10", in_ready, out_valid);
        end
    endtask

    task automatic test_special();
        logic [31:0] a[5] = '{32'h00000000, 32'h7FC00000, 32'hC0000000,
                              32'h80000000, 32'h7F800000};
        logic [31:0] b[5] = '{32'h7F800000, 32'h3F800000, 32'h7F800000,
                              32'h3F800000, 32'h7F800000};
        logic [31:0] p[5] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h7F800000};
        logic [2:0]  f[5] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        exp_t e;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            send(a[i], b[i], '{p[i], f[i], LS});
            wait_out(lat);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || lat != e.lat) begin
                bad++;
                $display("FAIL special_lat[%0d] got=%0d want=%0d",
                         i, lat, e.lat);
            end
            total++;
            if ({product, overflow, underflow, invalid} !== {e.p, e.f}) begin
                bad++;
                $display("FAIL special_res[%0d] got=%h/%b%b%b want=%h/%b",
                         i, product, overflow, underflow, invalid, e.p, e.f);
            end
            take();
        end
    endtask

    task automatic test_range();
        logic [31:0] a[2] = '{32'h7F000000, 32'h00800000};
        logic [31:0] b[2] = '{32'h40000000, 32'h3F000000};
        logic [31:0] p[2] = '{32'h7F800000, 32'h00000000};
        logic [2:0]  f[2] = '{3'b100, 3'b010};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            send(a[i], b[i], '{p[i], f[i], LN});
            wait_out(lat);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 ||
                {product, overflow, underflow, invalid} !== {e.p, e.f}) begin
                bad++;
                $display("FAIL range_res[%0d] got=%h/%b%b%b want=%h/%b",
                         i, product, overflow, underflow, invalid, e.p, e.f);
            end
            take();
        end
    endtask

    task automatic test_rounding();
        logic [31:0] a[2] = '{32'h3FC00001, 32'h3F800001};
        logic [31:0] b[2] = '{32'h3F800001, 32'h3F800001};
        logic [31:0] p[2] = '{32'h3FC00003, 32'h3F800002};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            send(a[i], b[i], '{p[i], 3'b000, LN});
            wait_out(lat);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 ||
                {product, overflow, underflow, invalid} !== {e.p, e.f}) begin
                bad++;
                $display("FAIL round_res[%0d] got=%h/%b%b%b want=%h/%b",
                         i, product, overflow, underflow, invalid, e.p, e.f);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        send(32'h7F000000, 32'h40000000, '{32'h7F800000, 3'b100, LN});
        wait_out(lat);
        e = sb.pop_front();
        // Operands offered while busy must be ignored.
        input_a  = 32'h3F800000;
        input_b  = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {product, overflow, underflow, invalid} !== {e.p, e.f}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%b%b/%h/%b%b%b want=10/%h/%b",
                         i, out_valid, in_ready, product,
                         overflow, underflow, invalid, e.p, e.f);
            end
            cyc();
        end
        in_valid = 1'b0;
        take();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got=%b%b want=10", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        send(32'h40400000, 32'h40000000, '{32'h40C00000, 3'b000, LN});
        repeat (9) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        void'(sb.pop_back());
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_state got=%b%b want=01", out_valid, in_ready);
        end
        send(32'h40400000, 32'h40000000, '{32'h40C00000, 3'b000, LN});
        wait_out(lat);
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || lat != e.lat ||
            {product, overflow, underflow, invalid} !== {e.p, e.f}) begin
            bad++;
            $display("FAIL abort_redo got=%h/%b%b%b lat=%0d want=%h/%b lat=%0d",
                     product, overflow, underflow, invalid, lat,
                     e.p, e.f, e.lat);
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[6] = '{32'h40400000, 32'h7FC00000, 32'h3FC00000,
                              32'hC0000000, 32'h3FC00001, 32'h7F000000};
        logic [31:0] b[6] = '{32'h40000000, 32'h3F800000, 32'h3FC00000,
                              32'h7F800000, 32'h3F800001, 32'h40000000};
        logic [31:0] p[6] = '{32'h40C00000, 32'h7FC00000, 32'h40100000,
                              32'hFF800000, 32'h3FC00003, 32'h7F800000};
        logic [2:0]  f[6] = '{3'b000, 3'b001, 3'b000,
                              3'b000, 3'b000, 3'b100};
        int got;
        int n;
        exp_t e;
        got = 0;
        n   = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(a[i], b[i], '{p[i], f[i], 0});
                end
            end
            begin
                while (got < 6 && n < 2000) begin
                    cyc();
                    n++;
                    if (out_valid) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL b2b_extra got=%h want=none", product);
                        end else begin
                            e = sb.pop_front();
                            total++;
                            if ({product, overflow, underflow, invalid}
                                !== {e.p, e.f}) begin
                                bad++;
                                $display("FAIL b2b_res[%0d] got=%h/%b%b%b want=%h/%b",
                                         got, product, overflow, underflow,
                                         invalid, e.p, e.f);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        total++;
        if (got != 6) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=6", got);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_rounding();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
